tagged_regfile: RTL and testbench

Parametrised architectural register file with per-register writer-tag (ROB index) tracking. It replaces the fixed 16x16, 2-read, single-rename register file. It adds configurable width, depth and port counts, and multi-port rename per cycle. It also adds selective (age-based) flush for branch recovery alongside the full flush. It sits between decode/rename (tag allocation, operand reads) and ROB commit (writebacks).

---
 rtl/regs_pkg.sv | 19 +
 rtl/regfile_scoreboard.sv | 58 +++++
 rtl/tagged_regfile.sv | 69 ++++++
 tb/tb_tagged_regfile.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regs_pkg.sv
// regs_pkg: shared register-file defaults, request types and ROB age helper
package regs_pkg;
  localparam int TAG_W = 3;
  localparam int DATA_W = 16;
  localparam int NREGS = 16;
  localparam int AW = $clog2(NREGS);
  typedef struct packed {
    logic [AW-1:0]    addr;
    logic [TAG_W-1:0] tag;
  } rn_req_t;
  typedef struct packed {
    logic [AW-1:0]     addr;
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
  } wb_req_t;
  function automatic int rob_age(input int tag, input int head, input int tw);
    return (tag - head) & ((1 << tw) - 1);
  endfunction
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy/writer-tag tracking with rename, commit clear and flush
module regfile_scoreboard #(
  parameter int NREGS = regs_pkg::NREGS,
  parameter int TAG_W = regs_pkg::TAG_W,
  parameter int NRN = 1,
  parameter int NWB = 2,
  localparam int AW = $clog2(NREGS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NRN-1:0]     rn_valid,
  input  logic [AW-1:0]      rn_addr [NRN],
  input  logic [TAG_W-1:0]   rn_tag [NRN],
  input  logic [NWB-1:0]     wb_valid,
  input  logic [AW-1:0]      wb_addr [NWB],
  input  logic [TAG_W-1:0]   wb_tag [NWB],
  input  logic               flush_all,
  input  logic               flush_valid,
  input  logic [TAG_W-1:0]   flush_tag,
  input  logic [TAG_W-1:0]   rob_head,
  output logic [NREGS-1:0]   busy,
  output logic [TAG_W-1:0]   tag [NREGS]
);
  import regs_pkg::*;
  logic [NREGS-1:0] busy_q, busy_d;
  logic [TAG_W-1:0] tag_q [NREGS];
  logic [TAG_W-1:0] tag_d [NREGS];
  always_comb begin
    busy_d = busy_q;
    tag_d = tag_q;
    for (int r = 1; r < NREGS; r++) begin
      for (int i = 0; i < NWB; i++)
        if (wb_valid[i] && wb_addr[i] == AW'(r) && tag_q[r] == wb_tag[i]) busy_d[r] = 1'b0;
      if (flush_valid && rob_age(int'(tag_q[r]), int'(rob_head), TAG_W)
          >= rob_age(int'(flush_tag), int'(rob_head), TAG_W)) busy_d[r] = 1'b0;
      if (!flush_all && !flush_valid)
        for (int j = 0; j < NRN; j++)
          if (rn_valid[j] && rn_addr[j] == AW'(r)) begin
            busy_d[r] = 1'b1;
            tag_d[r] = rn_tag[j];
          end
    end
    if (flush_all) busy_d = '0;
    busy_d[0] = 1'b0;
    tag_d[0] = '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      tag_q <= '{default: '0};
    end else begin
      busy_q <= busy_d;
      tag_q <= tag_d;
    end
  end
  assign busy = busy_q;
  assign tag = tag_q;
endmodule

// File: rtl/tagged_regfile.sv
// tagged_regfile: register file with registered read addresses and per-register writer tags
module tagged_regfile #(
  parameter int NREGS = regs_pkg::NREGS,
  parameter int DATA_W = regs_pkg::DATA_W,
  parameter int TAG_W = regs_pkg::TAG_W,
  parameter int NRD = 2,
  parameter int NRN = 1,
  parameter int NWB = 2,
  localparam int AW = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AW-1:0]     raddr [NRD],
  output logic [DATA_W-1:0] rdata [NRD],
  output logic [NRD-1:0]    rbusy,
  output logic [TAG_W-1:0]  rtag [NRD],
  input  logic [NRN-1:0]    rn_valid,
  input  logic [AW-1:0]     rn_addr [NRN],
  input  logic [TAG_W-1:0]  rn_tag [NRN],
  input  logic [NWB-1:0]    wb_valid,
  input  logic [AW-1:0]     wb_addr [NWB],
  input  logic [DATA_W-1:0] wb_data [NWB],
  input  logic [TAG_W-1:0]  wb_tag [NWB],
  input  logic              flush_all,
  input  logic              flush_valid,
  input  logic [TAG_W-1:0]  flush_tag,
  input  logic [TAG_W-1:0]  rob_head
);
  logic [DATA_W-1:0] data_q [NREGS];
  logic [DATA_W-1:0] data_d [NREGS];
  logic [AW-1:0]     raddr_q [NRD];
  logic [NREGS-1:0]  busy;
  logic [TAG_W-1:0]  tag [NREGS];
  regfile_scoreboard #(.NREGS(NREGS), .TAG_W(TAG_W), .NRN(NRN), .NWB(NWB)) u_sb (
    .clk(clk),
    .rst(rst),
    .rn_valid(rn_valid),
    .rn_addr(rn_addr),
    .rn_tag(rn_tag),
    .wb_valid(wb_valid),
    .wb_addr(wb_addr),
    .wb_tag(wb_tag),
    .flush_all(flush_all),
    .flush_valid(flush_valid),
    .flush_tag(flush_tag),
    .rob_head(rob_head),
    .busy(busy),
    .tag(tag)
  );
  always_comb begin
    data_d = data_q;
    for (int i = 0; i < NWB; i++)
      if (wb_valid[i] && wb_addr[i] != '0) data_d[wb_addr[i]] = wb_data[i];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '{default: '0};
      raddr_q <= '{default: '0};
    end else begin
      data_q <= data_d;
      raddr_q <= raddr;
    end
  end
  for (genvar p = 0; p < NRD; p++) begin : g_rd
    assign rdata[p] = data_q[raddr_q[p]];
    assign rbusy[p] = busy[raddr_q[p]];
    assign rtag[p] = tag[raddr_q[p]];
  end
endmodule

// File: tb/tb_tagged_regfile.sv
// tb_tagged_regfile: directed and seeded stimulus checked against a behavioural register-file model
module tb_tagged_regfile;
  localparam int NREGS = 16, DATA_W = 16, TAG_W = 3, NRD = 2, NRN = 1, NWB = 2, AW = 4;
  localparam int ROB = 1 << TAG_W;
  logic clk = 1'b0;
  logic rst;
  logic [AW-1:0]     raddr [NRD];
  logic [DATA_W-1:0] rdata [NRD];
  logic [NRD-1:0]    rbusy;
  logic [TAG_W-1:0]  rtag [NRD];
  logic [NRN-1:0]    rn_valid;
  logic [AW-1:0]     rn_addr [NRN];
  logic [TAG_W-1:0]  rn_tag [NRN];
  logic [NWB-1:0]    wb_valid;
  logic [AW-1:0]     wb_addr [NWB];
  logic [DATA_W-1:0] wb_data [NWB];
  logic [TAG_W-1:0]  wb_tag [NWB];
  logic              flush_all, flush_valid;
  logic [TAG_W-1:0]  flush_tag, rob_head;
  int checks = 0, errors = 0;
  bit live = 0;
  int m_data [NREGS];
  bit m_busy [NREGS];
  int m_tag [NREGS];
  int m_ra [NRD];
  tagged_regfile dut (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata), .rbusy(rbusy), .rtag(rtag),
    .rn_valid(rn_valid), .rn_addr(rn_addr), .rn_tag(rn_tag),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_tag(wb_tag),
    .flush_all(flush_all), .flush_valid(flush_valid), .flush_tag(flush_tag), .rob_head(rob_head)
  );
  always #5 clk = ~clk;
  function automatic int age(int x, int h);
    return (x - h + ROB) % ROB;
  endfunction
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(posedge clk) begin : model
    bit ob [NREGS];
    int ot [NREGS];
    ob = m_busy;
    ot = m_tag;
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        m_data[r] = 0;
        m_busy[r] = 0;
        m_tag[r] = 0;
      end
      for (int p = 0; p < NRD; p++) m_ra[p] = 0;
    end else begin
      for (int i = 0; i < NWB; i++)
        if (wb_valid[i] && wb_addr[i] != 0) begin
          m_data[wb_addr[i]] = int'(wb_data[i]);
          if (ob[wb_addr[i]] && ot[wb_addr[i]] == int'(wb_tag[i])) m_busy[wb_addr[i]] = 0;
        end
      if (flush_all) begin
        for (int r = 0; r < NREGS; r++) m_busy[r] = 0;
      end else if (flush_valid) begin
        for (int r = 0; r < NREGS; r++)
          if (ob[r] && age(ot[r], int'(rob_head)) >= age(int'(flush_tag), int'(rob_head))) m_busy[r] = 0;
      end else begin
        for (int j = 0; j < NRN; j++)
          if (rn_valid[j] && rn_addr[j] != 0) begin
            m_busy[rn_addr[j]] = 1;
            m_tag[rn_addr[j]] = int'(rn_tag[j]);
          end
      end
      for (int p = 0; p < NRD; p++) m_ra[p] = int'(raddr[p]);
    end
    live = 1;
  end
  always @(negedge clk)
    if (live)
      for (int p = 0; p < NRD; p++) begin
        chk($sformatf("model rdata%0d", p), int'(rdata[p]), m_data[m_ra[p]]);
        chk($sformatf("model rbusy%0d", p), int'(rbusy[p]), int'(m_busy[m_ra[p]]));
        if (m_busy[m_ra[p]]) chk($sformatf("model rtag%0d", p), int'(rtag[p]), m_tag[m_ra[p]]);
      end
  task automatic idle();
    rst = 0;
    rn_valid = '0;
    wb_valid = '0;
    flush_all = 0;
    flush_valid = 0;
    flush_tag = '0;
    rob_head = '0;
    for (int j = 0; j < NRN; j++) begin
      rn_addr[j] = '0;
      rn_tag[j] = '0;
    end
    for (int i = 0; i < NWB; i++) begin
      wb_addr[i] = '0;
      wb_data[i] = '0;
      wb_tag[i] = '0;
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    idle();
  endtask
  task automatic rn(int a, int t);
    rn_valid[0] = 1'b1;
    rn_addr[0] = AW'(a);
    rn_tag[0] = TAG_W'(t);
  endtask
  task automatic wb(int p, int a, int d, int t);
    wb_valid[p] = 1'b1;
    wb_addr[p] = AW'(a);
    wb_data[p] = DATA_W'(d);
    wb_tag[p] = TAG_W'(t);
  endtask
  task automatic rd(int a0, int a1);
    raddr[0] = AW'(a0);
    raddr[1] = AW'(a1);
  endtask
  initial begin
    idle();
    rd(0, 0);
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    rst = 1;
    cyc();
    rd(0, 1);
    cyc();
    chk("reset rdata r0", int'(rdata[0]), 0);
    chk("reset rbusy r1", int'(rbusy[1]), 0);
    rd(2, 3);
    cyc();
    chk("reset rdata r3", int'(rdata[1]), 0);
    rn(4, 2);
    rd(4, 4);
    cyc();
    chk("rn r4 busy", int'(rbusy[0]), 1);
    chk("rn r4 tag", int'(rtag[0]), 2);
    wb(0, 4, 'hBEEF, 2);
    cyc();
    chk("wb r4 busy", int'(rbusy[0]), 0);
    chk("wb r4 data", int'(rdata[0]), 'hBEEF);
    rn(4, 2);
    cyc();
    rn(4, 5);
    cyc();
    wb(0, 4, 'h1111, 2);
    cyc();
    chk("stale wb data", int'(rdata[0]), 'h1111);
    chk("stale wb busy", int'(rbusy[0]), 1);
    chk("stale wb tag", int'(rtag[0]), 5);
    wb(1, 4, 'h2222, 5);
    cyc();
    chk("tag5 clear", int'(rbusy[0]), 0);
    rn(7, 1);
    cyc();
    rd(7, 7);
    wb(0, 7, 'h77, 1);
    rn(7, 3);
    cyc();
    chk("rn over wb busy", int'(rbusy[0]), 1);
    chk("rn over wb tag", int'(rtag[1]), 3);
    chk("rn over wb data", int'(rdata[1]), 'h77);
    wb(0, 5, 'hAAAA, 0);
    wb(1, 5, 'hBBBB, 0);
    rd(5, 0);
    cyc();
    chk("wb port1 wins", int'(rdata[0]), 'hBBBB);
    wb(0, 0, 'h1234, 0);
    rn(0, 6);
    rd(0, 0);
    cyc();
    chk("r0 data", int'(rdata[0]), 0);
    chk("r0 busy", int'(rbusy[1]), 0);
    rob_head = 6;
    rn(1, 7);
    cyc();
    rob_head = 6;
    rn(2, 0);
    cyc();
    rob_head = 6;
    rn(3, 5);
    cyc();
    rob_head = 6;
    flush_valid = 1;
    flush_tag = 0;
    rn(9, 4);
    rd(1, 2);
    cyc();
    chk("flush keeps r1", int'(rbusy[0]), 1);
    chk("flush r1 tag", int'(rtag[0]), 7);
    chk("flush clears r2", int'(rbusy[1]), 0);
    rd(3, 9);
    cyc();
    chk("flush clears r3", int'(rbusy[0]), 0);
    chk("flush drops rn r9", int'(rbusy[1]), 0);
    rn(10, 1);
    cyc();
    flush_all = 1;
    flush_valid = 1;
    flush_tag = 7;
    wb(0, 8, 'h00AA, 0);
    rn(11, 2);
    rd(1, 8);
    cyc();
    chk("flush_all r1", int'(rbusy[0]), 0);
    chk("flush_all wb r8", int'(rdata[1]), 'h00AA);
    rd(10, 11);
    cyc();
    chk("flush_all r10", int'(rbusy[0]), 0);
    chk("flush_all drops r11", int'(rbusy[1]), 0);
    for (int k = 0; k < 60; k++) begin
      int a;
      rob_head = TAG_W'($urandom_range(ROB - 1));
      if ($urandom_range(3) != 0) rn($urandom_range(NREGS - 1), $urandom_range(ROB - 1));
      for (int i = 0; i < NWB; i++)
        if ($urandom_range(1) != 0) begin
          a = $urandom_range(NREGS - 1);
          wb(i, a, $urandom_range(16'hFFFF), $urandom_range(1) != 0 ? m_tag[a] : $urandom_range(ROB - 1));
        end
      flush_valid = ($urandom_range(7) == 0);
      flush_tag = TAG_W'($urandom_range(ROB - 1));
      flush_all = ($urandom_range(15) == 0);
      rd($urandom_range(NREGS - 1), $urandom_range(NREGS - 1));
      cyc();
    end
    rn(1, 3);
    wb(0, 8, 'h55, 0);
    cyc();
    rst = 1;
    rn(2, 4);
    wb(0, 8, 'h66, 0);
    rd(8, 1);
    cyc();
    chk("rst rdata", int'(rdata[0]), 0);
    chk("rst rbusy", int'(rbusy[1]), 0);
    rd(8, 2);
    cyc();
    chk("rst r8 data", int'(rdata[0]), 0);
    chk("rst r2 busy", int'(rbusy[1]), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
